// File: rtl/startup_sequencer_if.sv
// Checker-side handshake: configuration word out, pass/fail/false verdicts back.
interface startup_sequencer_if #(
  parameter int unsigned DATA_W = 56
);
  logic              valid_a;
  logic [DATA_W-1:0] data_a;
  logic              i_pass;
  logic              i_fail;
  logic              i_false;

  modport master (output valid_a, data_a, input i_pass, i_fail, i_false);
  modport slave  (input valid_a, data_a, output i_pass, i_fail, i_false);
endinterface

// File: rtl/startup_sequencer.sv
// Startup sequencer: walks a table of configuration words, one checker
// verdict per attempt, bounded retries per stage, then DONE or FAIL.
module startup_sequencer #(
  parameter int unsigned DATA_W       = 56,
  parameter int unsigned NUM_STAGES   = 3,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned ISSUE_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 15,
  parameter logic [NUM_STAGES-1:0] RAM_MASK = '0,
  localparam int unsigned STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         abort,
  input  logic [NUM_STAGES*DATA_W-1:0] cfg_table,
  startup_sequencer_if.master          chk_bus,
  output logic                         bsg_enable,
  output logic                         select_signal,
  output logic                         ram_fail,
  output logic                         startup_done,
  output logic                         seq_fail,
  output logic [STAGE_W-1:0]           fail_stage,
  output logic [2:0]                   retry_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 2);
  localparam logic [3:0]         ISSUE_LAST = 4'(ISSUE_CYCLES - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [2:0]         RETRY_MAX  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_FAIL} state_e;

  state_e             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [2:0]         retry_q, retry_d;
  logic [3:0]         icnt_q, icnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [STAGE_W-1:0] fstage_d;
  logic               ram_fail_d;
  logic               attempt_fail;
  logic               timeout_hit;
  logic               valid_d, bsg_d, select_d;
  logic [DATA_W-1:0]  data_d;
  logic [DATA_W-1:0]  words [NUM_STAGES];

  // Unpack the flat table into one word per stage.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_words
    assign words[g] = cfg_table[g*DATA_W +: DATA_W];
  end

  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMR_LAST);

  // Next-state, counter and next-output logic.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    retry_d      = retry_q;
    icnt_d       = icnt_q;
    timer_d      = timer_q;
    fstage_d     = '0;
    ram_fail_d   = 1'b0;
    attempt_fail = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ISSUE;
          stage_d = '0;
          retry_d = '0;
          icnt_d  = '0;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d  = S_FAIL;
          fstage_d = stage_q;
        end else if (icnt_q == ISSUE_LAST) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else begin
          icnt_d = icnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d  = S_FAIL;
          fstage_d = stage_q;
        end else if (chk_bus.i_fail || chk_bus.i_false) begin
          attempt_fail = 1'b1;
        end else if (chk_bus.i_pass) begin
          retry_d = '0;
          icnt_d  = '0;
          if (stage_q == STAGE_LAST) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else if (timeout_hit) begin
          attempt_fail = 1'b1;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end

        if (attempt_fail) begin
          retry_d    = retry_q + 3'd1;
          ram_fail_d = RAM_MASK[stage_q];
          if (retry_d == RETRY_MAX) begin
            state_d  = S_FAIL;
            fstage_d = stage_q;
          end else begin
            state_d = S_ISSUE;
            icnt_d  = '0;
          end
        end
      end
      S_DONE: begin
        if (enable) begin
          state_d = S_IDLE;
          stage_d = '0;
        end
      end
      S_FAIL: begin
        if (enable) begin
          state_d = S_IDLE;
          stage_d = '0;
          retry_d = '0;
        end else begin
          fstage_d = fail_stage;
        end
      end
      default: state_d = S_IDLE;
    endcase

    valid_d  = (state_d == S_ISSUE) && !RAM_MASK[stage_d];
    bsg_d    = (state_d == S_ISSUE) && RAM_MASK[stage_d];
    select_d = ((state_d == S_ISSUE) || (state_d == S_WAIT)) && RAM_MASK[stage_d];
    data_d   = '0;
    if (state_d == S_ISSUE) begin
      data_d = words[stage_d];
    end else if (state_d == S_WAIT) begin
      data_d = chk_bus.data_a;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      stage_q         <= '0;
      retry_q         <= '0;
      icnt_q          <= '0;
      timer_q         <= '0;
      chk_bus.valid_a <= 1'b0;
      chk_bus.data_a  <= '0;
      bsg_enable      <= 1'b0;
      select_signal   <= 1'b0;
      ram_fail        <= 1'b0;
      startup_done    <= 1'b0;
      seq_fail        <= 1'b0;
      fail_stage      <= '0;
      retry_cnt       <= '0;
    end else begin
      state_q         <= state_d;
      stage_q         <= stage_d;
      retry_q         <= retry_d;
      icnt_q          <= icnt_d;
      timer_q         <= timer_d;
      chk_bus.valid_a <= valid_d;
      chk_bus.data_a  <= data_d;
      bsg_enable      <= bsg_d;
      select_signal   <= select_d;
      ram_fail        <= ram_fail_d;
      startup_done    <= (state_d == S_DONE);
      seq_fail        <= (state_d == S_FAIL);
      fail_stage      <= fstage_d;
      retry_cnt       <= retry_d;
    end
  end

endmodule

// File: tb/tb_startup_sequencer.sv
// Bench for startup_sequencer: a per-attempt scenario script is expanded into
// a cycle-by-cycle stimulus and expected-output timeline, checked every cycle.
module tb_startup_sequencer;

  localparam int unsigned DW   = 56;
  localparam int unsigned NS   = 3;
  localparam int          IC   = 2;
  localparam int          MAXR = 2;

  typedef enum int {K_PASS, K_FAIL, K_FALSE, K_BOTH, K_NONE, K_AB_ISSUE, K_AB_WAIT} kind_e;
  typedef struct { int stage; kind_e kind; int at; } att_t;
  typedef struct { logic en; logic ab; logic ps; logic fl; logic fs; } stim_t;
  typedef struct {
    logic valid; logic [DW-1:0] data; logic bsg; logic sel; logic rf;
    logic done; logic sfail; int fstage; int retry;
  } obs_t;

  logic clk, rst_n;
  logic [NS*DW-1:0] cfg;
  logic [DW-1:0] words [NS];
  logic en [3];
  logic ab [3];
  logic bsg [3];
  logic selo [3];
  logic rf [3];
  logic done [3];
  logic sfail [3];
  logic [1:0] fst [3];
  logic [2:0] rty [3];

  int         to_of   [3] = '{15, 15, 4};
  logic [2:0] mask_of [3] = '{3'b000, 3'b001, 3'b000};

  att_t  att_q [$];
  stim_t stim_q [$];
  obs_t  exp_q [$];
  obs_t  cur_exp;
  int    cur_idx;
  logic  cur_valid;
  int    sel;
  int    n_chk, n_pass;

  startup_sequencer_if #(.DATA_W(DW)) if_def (), if_ram (), if_to ();

  startup_sequencer u_def (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .abort(ab[0]), .cfg_table(cfg),
    .chk_bus(if_def), .bsg_enable(bsg[0]), .select_signal(selo[0]), .ram_fail(rf[0]),
    .startup_done(done[0]), .seq_fail(sfail[0]), .fail_stage(fst[0]), .retry_cnt(rty[0]));

  startup_sequencer #(.RAM_MASK(3'b001)) u_ram (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .abort(ab[1]), .cfg_table(cfg),
    .chk_bus(if_ram), .bsg_enable(bsg[1]), .select_signal(selo[1]), .ram_fail(rf[1]),
    .startup_done(done[1]), .seq_fail(sfail[1]), .fail_stage(fst[1]), .retry_cnt(rty[1]));

  startup_sequencer #(.TIMEOUT(4)) u_to (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .abort(ab[2]), .cfg_table(cfg),
    .chk_bus(if_to), .bsg_enable(bsg[2]), .select_signal(selo[2]), .ram_fail(rf[2]),
    .startup_done(done[2]), .seq_fail(sfail[2]), .fail_stage(fst[2]), .retry_cnt(rty[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cur_idx, act, expv);
  endtask

  function automatic obs_t zobs();
    obs_t o;
    o.valid = 1'b0; o.data = '0; o.bsg = 1'b0; o.sel = 1'b0; o.rf = 1'b0;
    o.done = 1'b0; o.sfail = 1'b0; o.fstage = 0; o.retry = 0;
    return o;
  endfunction

  function automatic stim_t zst();
    stim_t s;
    s.en = 1'b0; s.ab = 1'b0; s.ps = 1'b0; s.fl = 1'b0; s.fs = 1'b0;
    return s;
  endfunction

  task automatic get_obs(output obs_t o);
    o = zobs();
    case (sel)
      0: begin o.valid = if_def.valid_a; o.data = if_def.data_a; end
      1: begin o.valid = if_ram.valid_a; o.data = if_ram.data_a; end
      default: begin o.valid = if_to.valid_a; o.data = if_to.data_a; end
    endcase
    o.bsg = bsg[sel]; o.sel = selo[sel]; o.rf = rf[sel]; o.done = done[sel];
    o.sfail = sfail[sel]; o.fstage = int'(fst[sel]); o.retry = int'(rty[sel]);
  endtask

  task automatic drive(input stim_t s);
    for (int i = 0; i < 3; i++) begin en[i] = 1'b0; ab[i] = 1'b0; end
    if_def.i_pass = 1'b0; if_def.i_fail = 1'b0; if_def.i_false = 1'b0;
    if_ram.i_pass = 1'b0; if_ram.i_fail = 1'b0; if_ram.i_false = 1'b0;
    if_to.i_pass  = 1'b0; if_to.i_fail  = 1'b0; if_to.i_false  = 1'b0;
    en[sel] = s.en; ab[sel] = s.ab;
    case (sel)
      0: begin if_def.i_pass = s.ps; if_def.i_fail = s.fl; if_def.i_false = s.fs; end
      1: begin if_ram.i_pass = s.ps; if_ram.i_fail = s.fl; if_ram.i_false = s.fs; end
      default: begin if_to.i_pass = s.ps; if_to.i_fail = s.fl; if_to.i_false = s.fs; end
    endcase
  endtask

  task automatic push(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic add(input int st, input kind_e k, input int at);
    att_t a;
    a.stage = st; a.kind = k; a.at = at;
    att_q.push_back(a);
  endtask

  // FAIL hold (abort ignored), leave with enable, then IDLE.
  task automatic end_fail(input int st, input int r, input logic rfl);
    obs_t e; stim_t s;
    e = zobs(); e.sfail = 1'b1; e.fstage = st; e.retry = r; e.rf = rfl;
    s = zst(); s.ab = 1'b1; push(s, e);
    e.rf = 1'b0; s = zst(); s.en = 1'b1; push(s, e);
    push(zst(), zobs());
  endtask

  task automatic end_done();
    obs_t e; stim_t s;
    e = zobs(); e.done = 1'b1;
    s = zst(); s.ab = 1'b1; push(s, e);
    s = zst(); s.en = 1'b1; push(s, e);
    push(zst(), zobs());
  endtask

  // Expand att_q into per-cycle stimulus and expected outputs.
  task automatic build(input int inst);
    int retry; logic pend; obs_t e; stim_t s; int nw; int st; logic ram; kind_e k;
    stim_q.delete(); exp_q.delete();
    retry = 0; pend = 1'b0;
    s = zst(); s.ab = 1'b1; push(s, zobs());
    s = zst(); s.en = 1'b1; push(s, zobs());
    foreach (att_q[n]) begin
      st = att_q[n].stage; k = att_q[n].kind; ram = mask_of[inst][st];
      for (int i = 0; i < IC; i++) begin
        e = zobs(); e.valid = !ram; e.data = words[st]; e.bsg = ram; e.sel = ram;
        e.rf = (i == 0) && pend; e.retry = retry;
        s = zst(); s.fs = (i == 0);
        if (k == K_AB_ISSUE && i == att_q[n].at) begin
          s.ab = 1'b1; push(s, e); end_fail(st, retry, 1'b0); return;
        end
        push(s, e);
      end
      pend = 1'b0;
      nw = (k == K_NONE) ? to_of[inst] : att_q[n].at + 1;
      for (int j = 0; j < nw; j++) begin
        e = zobs(); e.data = words[st]; e.sel = ram; e.retry = retry;
        s = zst();
        if (j == nw - 1) begin
          case (k)
            K_PASS:    s.ps = 1'b1;
            K_FAIL:    s.fl = 1'b1;
            K_FALSE:   s.fs = 1'b1;
            K_BOTH:    begin s.ps = 1'b1; s.fl = 1'b1; end
            K_AB_WAIT: s.ab = 1'b1;
            default:   ;
          endcase
        end
        push(s, e);
      end
      case (k)
        K_PASS: begin
          retry = 0;
          if (st == NS - 1) begin end_done(); return; end
        end
        K_AB_WAIT: begin end_fail(st, retry, 1'b0); return; end
        default: begin
          retry++; pend = ram;
          if (retry == MAXR) begin end_fail(st, retry, pend); return; end
        end
      endcase
    end
  endtask

  function automatic int first_idx(input int which);
    foreach (exp_q[i]) begin
      if (which == 0 && exp_q[i].done)  return i;
      if (which == 1 && exp_q[i].sfail) return i;
      if (which == 2 && exp_q[i].rf)    return i;
    end
    return -1;
  endfunction

  task automatic run(input int inst, input int stop_after);
    sel = inst;
    for (int c = 0; c < stim_q.size(); c++) begin
      @(posedge clk); #1;
      drive(stim_q[c]); cur_exp = exp_q[c]; cur_idx = c; cur_valid = 1'b1;
      if (stop_after >= 0 && c == stop_after) return;
    end
    @(posedge clk); #1;
    cur_valid = 1'b0; drive(zst());
  endtask

  // Per-cycle comparison of the selected DUT against the timeline.
  initial forever begin
    obs_t o;
    @(negedge clk);
    if (cur_valid) begin
      get_obs(o);
      chk("valid_a", 64'(o.valid), 64'(cur_exp.valid));
      chk("data_a", 64'(o.data), 64'(cur_exp.data));
      chk("bsg_enable", 64'(o.bsg), 64'(cur_exp.bsg));
      chk("select_signal", 64'(o.sel), 64'(cur_exp.sel));
      chk("ram_fail", 64'(o.rf), 64'(cur_exp.rf));
      chk("startup_done", 64'(o.done), 64'(cur_exp.done));
      chk("seq_fail", 64'(o.sfail), 64'(cur_exp.sfail));
      chk("fail_stage", 64'(o.fstage), 64'(cur_exp.fstage));
      chk("retry_cnt", 64'(o.retry), 64'(cur_exp.retry));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t o;
    n_chk = 0; n_pass = 0; cur_valid = 1'b0; cur_idx = 0; sel = 0;
    cur_exp = zobs();
    words[0] = 56'h110100ffeaff01;
    words[1] = 56'h110102ffeaff01;
    words[2] = 56'h110103ffeaff01;
    cfg = {words[2], words[1], words[0]};
    drive(zst());
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state of all instances.
    sel = 0; get_obs(o);
    chk("reset_valid", 64'(o.valid), 64'd0);
    chk("reset_data", 64'(o.data), 64'd0);
    chk("reset_done", 64'(o.done), 64'd0);

    // Clean pass through all three stages.
    att_q.delete(); add(0, K_PASS, 0); add(1, K_PASS, 0); add(2, K_PASS, 0);
    build(0);
    chk("pin_s1_done_cycle", 64'(first_idx(0) - 1), 64'd10);
    run(0, -1);

    // Stage 1 fails once, then passes.
    att_q.delete(); add(0, K_PASS, 0); add(1, K_FAIL, 0); add(1, K_PASS, 0); add(2, K_PASS, 0);
    build(0);
    chk("pin_s2_done_cycle", 64'(first_idx(0) - 1), 64'd13);
    chk("pin_s2_retry_seen", 64'(exp_q[9].retry), 64'd1);
    run(0, -1);

    // Stage 2 false twice -> FAIL at stage 2.
    att_q.delete(); add(0, K_PASS, 0); add(1, K_PASS, 0); add(2, K_FALSE, 0); add(2, K_FALSE, 0);
    build(0);
    chk("pin_s3_fail_cycle", 64'(first_idx(1) - 1), 64'd13);
    chk("pin_s3_fail_stage", 64'(exp_q[first_idx(1)].fstage), 64'd2);
    chk("pin_s3_retry", 64'(exp_q[first_idx(1)].retry), 64'd2);
    run(0, -1);

    // RAM stage 0 fails once, then normal stages.
    att_q.delete(); add(0, K_FAIL, 0); add(0, K_PASS, 0); add(1, K_PASS, 0); add(2, K_PASS, 1);
    build(1);
    chk("pin_s4_ram_fail_cycle", 64'(first_idx(2) - 1), 64'd4);
    run(1, -1);

    // Timeout of 4 with no verdict, twice.
    att_q.delete(); add(0, K_NONE, 0); add(0, K_NONE, 0);
    build(2);
    chk("pin_s5_fail_cycle", 64'(first_idx(1) - 1), 64'd13);
    run(2, -1);

    // Pass+fail together counts as fail; pass on the last timer cycle wins.
    att_q.delete(); add(0, K_BOTH, 1); add(0, K_PASS, 0); add(1, K_PASS, 2); add(2, K_PASS, 3);
    build(2);
    run(2, -1);

    // Abort mid-ISSUE at stage 1.
    att_q.delete(); add(0, K_PASS, 0); add(1, K_AB_ISSUE, 1);
    build(0);
    chk("pin_s7_fail_cycle", 64'(first_idx(1) - 1), 64'd6);
    chk("pin_s7_fail_stage", 64'(exp_q[first_idx(1)].fstage), 64'd1);
    run(0, -1);

    // Abort in WAIT at stage 2 after one failed attempt.
    att_q.delete(); add(0, K_PASS, 0); add(1, K_PASS, 0); add(2, K_FAIL, 0); add(2, K_AB_WAIT, 2);
    build(0);
    run(0, -1);

    // Reset asserted mid-WAIT (stage 1, retry 1) clears everything at once.
    att_q.delete(); add(0, K_PASS, 0); add(1, K_FAIL, 0); add(1, K_PASS, 0); add(2, K_PASS, 0);
    build(0);
    run(0, 10);
    @(negedge clk); #2;
    cur_valid = 1'b0; drive(zst());
    rst_n = 1'b0;
    #1;
    get_obs(o);
    chk("rst_mid_valid", 64'(o.valid), 64'd0);
    chk("rst_mid_data", 64'(o.data), 64'd0);
    chk("rst_mid_retry", 64'(o.retry), 64'd0);
    chk("rst_mid_done", 64'(o.done), 64'd0);
    chk("rst_mid_fail", 64'(o.sfail), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh sequence after reset.
    att_q.delete(); add(0, K_PASS, 0); add(1, K_PASS, 0); add(2, K_PASS, 0);
    build(0);
    run(0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
